// File: rtl/select_arb_pkg.sv
// Shared constants and helpers for the N-channel select/arbitrate block.
package select_pkg;

    localparam int unsigned MODE_MANUAL = 0;
    localparam int unsigned MODE_RR     = 1;

    // Channel index width, never narrower than one bit.
    function automatic int unsigned cw_of(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/select_arb_if.sv
// Producer-side and consumer-side handshake bundle for select_arb.
interface select_arb_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CW = select_pkg::cw_of(N_CH);

    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [CW-1:0]         cntrl;
    logic [WIDTH-1:0]      out_data;
    logic [CW-1:0]         out_chan;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  in_data, in_valid, cntrl, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    modport master (
        output in_data, in_valid, cntrl, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

endinterface

// File: rtl/select_rr_arb.sv
// Combinational round-robin search: first requester at or after ptr, wrapping.
module select_rr_arb
    import select_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    localparam int unsigned CW  = cw_of(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   ptr,
    output logic [N_CH-1:0] gnt,
    output logic [CW-1:0]   gnt_idx,
    output logic            any
);

    logic [N_CH-1:0] rot;
    logic [CW-1:0]   off;
    logic [CW:0]     sum;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate the index back.
    always_comb begin
        rot = N_CH'({req, req} >> ptr);
        off = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                off = CW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (CW+1)'(N_CH)) begin
            sum = sum - (CW+1)'(N_CH);
        end
        gnt_idx = sum[CW-1:0];
        gnt     = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            gnt[i] = any && (gnt_idx == CW'(i));
        end
    end

endmodule

// File: rtl/select_arb.sv
// N-channel selector with a registered output stage; manual or round-robin grant.
module select_arb
    import select_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MODE  = MODE_RR
) (
    input logic        clk,
    input logic        rst,
    select_arb_if.slave bus
);

    localparam int unsigned CW = cw_of(N_CH);

    logic [N_CH-1:0]  gnt;
    logic [CW-1:0]    gnt_idx;
    logic             gnt_any;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;

    if (MODE == MODE_RR) begin : g_rr
        logic [CW-1:0] ptr_q, ptr_d;
        logic          unused_cntrl;

        assign unused_cntrl = ^bus.cntrl;

        select_rr_arb #(.N_CH(N_CH)) u_arb (
            .req     (bus.in_valid),
            .ptr     (ptr_q),
            .gnt     (gnt),
            .gnt_idx (gnt_idx),
            .any     (gnt_any)
        );

        // Pointer moves just past the channel that transferred; otherwise holds.
        always_comb begin
            ptr_d = ptr_q;
            if (xfer) begin
                ptr_d = (gnt_idx == CW'(N_CH - 1)) ? '0 : gnt_idx + CW'(1);
            end
        end

        // Round-robin pointer register.
        always_ff @(posedge clk) begin
            if (rst) ptr_q <= '0;
            else     ptr_q <= ptr_d;
        end
    end else begin : g_man
        // Only the channel named by cntrl is eligible; out-of-range cntrl grants nothing.
        always_comb begin
            gnt     = '0;
            gnt_idx = '0;
            gnt_any = 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (bus.cntrl == CW'(i) && bus.in_valid[i]) begin
                    gnt[i]  = 1'b1;
                    gnt_idx = CW'(i);
                    gnt_any = 1'b1;
                end
            end
        end
    end

    // Handshake: accept only when the output register is free or draining.
    always_comb begin
        load         = !out_valid_q || bus.out_ready;
        xfer         = !rst && load && gnt_any;
        bus.in_ready = xfer ? gnt : '0;
        sel_data     = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (gnt[i]) sel_data = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    // Output register next state: load on transfer, drop valid on an empty load slot.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_data_d  = sel_data;
            out_chan_d  = gnt_idx;
            out_valid_d = 1'b1;
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;

endmodule
